// File: rtl/fir_stream_core.sv
// Streaming 8-tap direct-form FIR: delay line, registered products, registered sum, then shift/saturate.
// Optional build macro FIR_ROUND_EN selects round-half-up instead of truncation in the output stage.
module fir_stream_core #(
  parameter int INPUT_DATA_W  = 14,
  parameter int OUTPUT_DATA_W = 16,
  parameter int COEF_W        = 12,
  parameter int TAPS          = 8,
  parameter int OUT_SHIFT     = 8,
  parameter logic [TAPS*COEF_W-1:0] COEFS = {12'sd64, 12'sd128, 12'sd256, 12'sd512,
                                             12'sd512, 12'sd256, 12'sd128, 12'sd64}
) (
  input  logic                            clk,
  input  logic                            i_rst,
  input  logic                            ValidIn,
  input  logic signed [INPUT_DATA_W-1:0]  FilterIn,
  output logic                            ValidOut,
  output logic signed [OUTPUT_DATA_W-1:0] FilterOut
);

  localparam int PROD_W = INPUT_DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + $clog2(TAPS);
  // One guard bit so the rounding bias can never wrap the accumulator.
  localparam int ACC_W  = SUM_W + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUTPUT_DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`ifdef FIR_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(64'sd1 <<< (OUT_SHIFT - 1));
`endif

  logic signed [INPUT_DATA_W-1:0]  taps [TAPS];
  logic signed [PROD_W-1:0]        prod [TAPS];
  logic signed [SUM_W-1:0]         sum;
  logic signed [SUM_W-1:0]         sum_next;
  logic signed [ACC_W-1:0]         acc;
  logic signed [ACC_W-1:0]         shifted;
  logic signed [OUTPUT_DATA_W-1:0] sat_val;
  logic                            valid_s0;
  logic                            valid_s1;
  logic                            valid_s2;

  function automatic logic signed [COEF_W-1:0] coef(input int k);
    return COEFS[k*COEF_W +: COEF_W];
  endfunction

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
      valid_s0 <= 1'b0;
    end else begin
      valid_s0 <= ValidIn;
      // The delay line only moves on accepted samples, so idle input data never enters it.
      if (ValidIn) begin
        taps[0] <= FilterIn;
        for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      valid_s1 <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) prod[k] <= PROD_W'(taps[k]) * PROD_W'(coef(k));
      valid_s1 <= valid_s0;
    end
  end

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < TAPS; k++) sum_next = sum_next + SUM_W'(prod[k]);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      sum      <= '0;
      valid_s2 <= 1'b0;
    end else begin
      sum      <= sum_next;
      valid_s2 <= valid_s1;
    end
  end

  always_comb begin
`ifdef FIR_ROUND_EN
    acc = ACC_W'(sum) + ROUND_BIAS;
`else
    acc = ACC_W'(sum);
`endif
    shifted = acc >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[OUTPUT_DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[OUTPUT_DATA_W-1:0];
    end else begin
      sat_val = shifted[OUTPUT_DATA_W-1:0];
    end
  end

  // Idle cycles recompute the held delay line, so FilterOut naturally keeps its last value.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      ValidOut  <= 1'b0;
      FilterOut <= '0;
    end else begin
      ValidOut  <= valid_s2;
      FilterOut <= sat_val;
    end
  end

endmodule
